addr_sequencer: RTL and testbench

Row-level transfer sequencer that drives the address calculator and the SRAM/SDRAM controller request handshakes for one image pass. Per row it fills the SRAM row cache from SDRAM, hands the row to the filter and waits for completion, then drains the SRAM output region back to SDRAM. It sits between the top-level control FSM and address_calc, and owns the mode/update/start_flag inputs of address_calc.

---
 rtl/addr_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_addr_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_sequencer.sv
// Row-level transfer sequencer: fills the SRAM row cache from SDRAM, hands the row to the filter,
// then drains the SRAM output region back to SDRAM, one row at a time, for a whole image.
module addr_sequencer #(
    parameter int unsigned WIDTH_BITS  = 13,
    parameter int unsigned HEIGHT_BITS = 13
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [WIDTH_BITS-1:0]  image_width,
    input  logic [HEIGHT_BITS-1:0] image_height,
    input  logic                   sdram_ack,
    input  logic                   sram_ack,
    input  logic                   filter_done,
    output logic                   sdram_req,
    output logic                   sram_req,
    output logic                   sram_rw,
    output logic                   start_flag,
    output logic                   sram_mode,
    output logic                   sdram_mode,
    output logic                   sram_update,
    output logic                   sdram_update,
    output logic                   filter_start,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StFillRd,
        StFillWr,
        StFilter,
        StDrainRd,
        StDrainWr,
        StDone
    } state_e;

    state_e                 state_q;
    logic [WIDTH_BITS-1:0]  col_q;
    logic [WIDTH_BITS-1:0]  width_q;
    logic [HEIGHT_BITS-1:0] row_q;
    logic [HEIGHT_BITS-1:0] height_q;
    logic [WIDTH_BITS-1:0]  col_inc;
    logic [HEIGHT_BITS-1:0] row_inc;

    assign col_inc = col_q + WIDTH_BITS'(1);
    assign row_inc = row_q + HEIGHT_BITS'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            sdram_req    <= 1'b0;
            sram_req     <= 1'b0;
            sram_rw      <= 1'b0;
            start_flag   <= 1'b0;
            sram_mode    <= 1'b1;
            sdram_mode   <= 1'b1;
            sram_update  <= 1'b0;
            sdram_update <= 1'b0;
            filter_start <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            start_flag   <= 1'b0;
            sram_update  <= 1'b0;
            sdram_update <= 1'b0;
            filter_start <= 1'b0;
            done         <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        width_q  <= image_width;
                        height_q <= image_height;
                        busy     <= 1'b1;
                        if (image_width == '0 || image_height == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q    <= StInit;
                            start_flag <= 1'b1;
                        end
                    end
                end

                StInit: begin
                    col_q     <= '0;
                    row_q     <= '0;
                    sdram_req <= 1'b1;
                    state_q   <= StFillRd;
                end

                StFillRd: begin
                    if (sdram_req && sdram_ack) begin
                        sdram_req    <= 1'b0;
                        sdram_update <= 1'b1;
                        sram_req     <= 1'b1;
                        sram_rw      <= 1'b1;
                        state_q      <= StFillWr;
                    end else if (!sdram_req) begin
                        // Entered from a drain: the last sdram_update used write mode, so the
                        // modes flip one cycle after it and the request follows with them.
                        sram_mode  <= 1'b1;
                        sdram_mode <= 1'b1;
                        sdram_req  <= 1'b1;
                    end
                end

                StFillWr: begin
                    if (sram_req && sram_ack) begin
                        sram_req    <= 1'b0;
                        sram_rw     <= 1'b0;
                        sram_update <= 1'b1;
                        if (col_inc == width_q) begin
                            col_q        <= '0;
                            filter_start <= 1'b1;
                            state_q      <= StFilter;
                        end else begin
                            col_q     <= col_inc;
                            sdram_req <= 1'b1;
                            state_q   <= StFillRd;
                        end
                    end
                end

                StFilter: begin
                    if (filter_done) begin
                        sram_req   <= 1'b1;
                        sram_rw    <= 1'b0;
                        sram_mode  <= 1'b0;
                        sdram_mode <= 1'b0;
                        state_q    <= StDrainRd;
                    end
                end

                StDrainRd: begin
                    if (sram_req && sram_ack) begin
                        sram_req    <= 1'b0;
                        sram_update <= 1'b1;
                        sdram_req   <= 1'b1;
                        state_q     <= StDrainWr;
                    end
                end

                StDrainWr: begin
                    if (sdram_req && sdram_ack) begin
                        sdram_req    <= 1'b0;
                        sdram_update <= 1'b1;
                        if (col_inc == width_q) begin
                            col_q <= '0;
                            row_q <= row_inc;
                            if (row_inc == height_q) begin
                                done    <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                state_q <= StFillRd;
                            end
                        end else begin
                            col_q    <= col_inc;
                            sram_req <= 1'b1;
                            state_q  <= StDrainRd;
                        end
                    end
                end

                StDone: begin
                    // Modes return to read/cache here, a cycle after the final sdram_update.
                    sram_mode  <= 1'b1;
                    sdram_mode <= 1'b1;
                    busy       <= 1'b0;
                    state_q    <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_sequencer.sv
// Scoreboard bench for addr_sequencer: stimulus queues expected per-pass pulse counts, a monitor
// counts pulses and protocol violations and compares them whenever done fires.
module tb_addr_sequencer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [12:0] image_width = '0;
    logic [12:0] image_height = '0;
    logic        sdram_ack = 1'b0;
    logic        sram_ack = 1'b0;
    logic        filter_done = 1'b0;
    logic        sdram_req, sram_req, sram_rw, start_flag, sram_mode, sdram_mode;
    logic        sram_update, sdram_update, filter_start, busy, done;

    always #5 clk = ~clk;

    addr_sequencer #(
        .WIDTH_BITS (13),
        .HEIGHT_BITS(13)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .image_width (image_width),
        .image_height(image_height),
        .sdram_ack   (sdram_ack),
        .sram_ack    (sram_ack),
        .filter_done (filter_done),
        .sdram_req   (sdram_req),
        .sram_req    (sram_req),
        .sram_rw     (sram_rw),
        .start_flag  (start_flag),
        .sram_mode   (sram_mode),
        .sdram_mode  (sdram_mode),
        .sram_update (sram_update),
        .sdram_update(sdram_update),
        .filter_start(filter_start),
        .busy        (busy),
        .done        (done)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int sf;
        int sd;
        int sr;
        int fs;
    } exp_t;
    exp_t exp_q[$];

    // {sdram_req, sram_req, sram_rw, start_flag, sram_mode, sdram_mode,
    //  sram_update, sdram_update, filter_start, busy, done}
    localparam logic [10:0] IdleOuts = 11'b00001100000;

    function automatic logic [10:0] outs();
        return {sdram_req, sram_req, sram_rw, start_flag, sram_mode, sdram_mode,
                sram_update, sdram_update, filter_start, busy, done};
    endfunction

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Responder: acks after ack_lat+1 cycles of req, filter_done filt_lat cycles after filter_start.
    int ack_lat = 0;
    int filt_lat = 0;
    bit abuse = 1'b0;
    int sd_cnt = 0;
    int sr_cnt = 0;
    int f_cnt = 0;
    bit f_pend = 1'b0;

    always @(posedge clk) begin
        #2;
        sdram_ack   = 1'b0;
        sram_ack    = 1'b0;
        filter_done = 1'b0;
        if (sdram_req) begin
            if (sd_cnt >= ack_lat) begin
                sdram_ack = 1'b1;
                sd_cnt = 0;
            end else sd_cnt++;
        end else sd_cnt = 0;
        if (sram_req) begin
            if (sr_cnt >= ack_lat) begin
                sram_ack = 1'b1;
                sr_cnt = 0;
            end else sr_cnt++;
        end else sr_cnt = 0;
        if (f_pend) begin
            if (f_cnt == 0) begin
                filter_done = 1'b1;
                f_pend = 1'b0;
            end else f_cnt--;
        end
        if (filter_start) begin
            f_pend = 1'b1;
            f_cnt = filt_lat;
        end
        if (abuse && sdram_req && sdram_mode) sram_ack = 1'b1;
        if (abuse && sram_req && sram_rw) filter_done = 1'b1;
        if (!n_rst) f_pend = 1'b0;
    end

    // Monitor
    int sf_c = 0, sd_c = 0, sr_c = 0, fs_c = 0, viol = 0, drain_wr_c = 0, pass_cnt = 0;
    bit prev_sd_hs = 0, prev_sr_hs = 0, prev_sd_req = 0, prev_sr_req = 0;
    bit prev_sd_ack = 0, prev_sr_ack = 0, prev_sram_mode = 1, prev_sdram_mode = 1, busy_chk = 0;

    always @(negedge clk) begin
        if (!n_rst) begin
            sf_c = 0; sd_c = 0; sr_c = 0; fs_c = 0; viol = 0; drain_wr_c = 0;
            prev_sd_hs = 0; prev_sr_hs = 0; prev_sd_req = 0; prev_sr_req = 0;
            prev_sd_ack = 0; prev_sr_ack = 0; prev_sram_mode = 1; prev_sdram_mode = 1;
            busy_chk = 0;
        end else begin
            if (busy_chk) begin
                cmp("busy_after_done", int'(busy), 0);
                busy_chk = 0;
            end
            sf_c += int'(start_flag);
            sd_c += int'(sdram_update);
            sr_c += int'(sram_update);
            fs_c += int'(filter_start);
            if (sdram_req && sram_req) viol++;
            if (sdram_update && sram_update) viol++;
            if (sdram_update !== prev_sd_hs) viol++;
            if (sram_update !== prev_sr_hs) viol++;
            if (prev_sd_req && !prev_sd_ack && !sdram_req) viol++;
            if (prev_sr_req && !prev_sr_ack && !sram_req) viol++;
            if (sdram_update && (sram_mode !== prev_sram_mode)) viol++;
            if (sram_update && (sdram_mode !== prev_sdram_mode)) viol++;
            if (sdram_update && !sdram_mode) drain_wr_c++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pass pending");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    cmp("start_flag_pulses", sf_c, e.sf);
                    cmp("sdram_update_pulses", sd_c, e.sd);
                    cmp("sram_update_pulses", sr_c, e.sr);
                    cmp("filter_start_pulses", fs_c, e.fs);
                    cmp("protocol_violations", viol, 0);
                end
                sf_c = 0; sd_c = 0; sr_c = 0; fs_c = 0; viol = 0; drain_wr_c = 0;
                pass_cnt++;
                busy_chk = 1;
            end
            prev_sd_hs = sdram_req && sdram_ack;
            prev_sr_hs = sram_req && sram_ack;
            prev_sd_req = sdram_req;
            prev_sr_req = sram_req;
            prev_sd_ack = sdram_ack;
            prev_sr_ack = sram_ack;
            prev_sram_mode = sram_mode;
            prev_sdram_mode = sdram_mode;
        end
    end

    task automatic check_idle(input string name);
        checks++;
        if (outs() !== IdleOuts) begin
            failures++;
            $display("FAIL %s: got outputs %b expected %b", name, outs(), IdleOuts);
        end
    endtask

    task automatic wait_pass(input int target, input string name);
        int n = 0;
        while (pass_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pass_cnt < target) begin
            failures++;
            $display("FAIL %s_timeout: got passes=%0d expected %0d", name, pass_cnt, target);
            exp_q.delete();
        end
    endtask

    task automatic run_pass(input int w, input int h, input int lat, input int flt,
                            input bit ab, input string name);
        exp_t e;
        int target;
        ack_lat = lat;
        filt_lat = flt;
        target = pass_cnt + 1;
        e.sf = (w != 0 && h != 0) ? 1 : 0;
        e.sd = 2 * w * h;
        e.sr = 2 * w * h;
        e.fs = (w != 0 && h != 0) ? h : 0;
        exp_q.push_back(e);
        @(negedge clk);
        abuse = ab;
        image_width = 13'(w);
        image_height = 13'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (ab) begin
            repeat (6) @(negedge clk);
            start = 1'b1;
            image_width = 13'd7;
            image_height = 13'd9;
            repeat (3) @(negedge clk);
            start = 1'b0;
        end
        wait_pass(target, name);
        abuse = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("idle_after_reset");
        end

        run_pass(3, 2, 0, 0, 1'b0, "pass_3x2");
        run_pass(3, 2, 3, 10, 1'b0, "pass_3x2_slow");
        run_pass(0, 5, 0, 0, 1'b0, "pass_w0");
        run_pass(4, 0, 0, 0, 1'b0, "pass_h0");
        run_pass(3, 2, 0, 0, 1'b1, "pass_abuse");
        run_pass(1, 1, 1, 2, 1'b0, "pass_1x1");

        // Abort in row 1, column 1 of the drain; no expectation queued for this pass.
        ack_lat = 0;
        filt_lat = 0;
        @(negedge clk);
        image_width = 13'd3;
        image_height = 13'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (drain_wr_c < 4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        cmp("reach_row1_col1", (drain_wr_c >= 4) ? 1 : 0, 1);
        n_rst = 1'b0;
        #1;
        check_idle("reset_mid_drain");
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("idle_after_release");
        end
        run_pass(3, 2, 0, 0, 1'b0, "pass_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
